// File: rtl/oled_pixel_streamer.sv
// SSD1331-class OLED master: walks pixel_index over the raster, re-sends the window command each frame, streams RGB565 over 4-wire SPI.
// Define OLED_TEST_PATTERN_EN to replace pixel_data with an internal 8-bar colour pattern.
module oled_pixel_streamer #(
  parameter int X_SIZE         = 96,
  parameter int Y_SIZE         = 64,
  parameter int POWERUP_CYCLES = 20,
  parameter int GAP_CYCLES     = 2
) (
  input  logic        clksig,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        cs_n,
  output logic        dc,
  output logic        sclk,
  output logic        mosi,
  output logic        frame_begin,
  output logic        sending_pixels
);

  localparam int NPIX     = X_SIZE * Y_SIZE;
  localparam int WAIT_MAX = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;

  localparam logic [12:0]       LAST_PIX = 13'(NPIX - 1);
  localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(POWERUP_CYCLES - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_POWERUP,
    S_CMD,
    S_STREAM,
    S_GAP
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic              r_phase,  w_phase_nxt;
  logic [3:0]        r_bit,    w_bit_nxt;
  logic [2:0]        r_byte,   w_byte_nxt;
  logic [12:0]       r_pix,    w_pix_nxt;
  logic [WAIT_W-1:0] r_wait,   w_wait_nxt;
  logic [15:0]       r_shift,  w_shift_nxt;
  logic [12:0]       r_index,  w_index_nxt;
  logic              r_cs_n,   w_cs_n_nxt;
  logic              r_dc,     w_dc_nxt;
  logic              r_sclk,   w_sclk_nxt;
  logic              r_mosi,   w_mosi_nxt;
  logic              r_fb,     w_fb_nxt;
  logic              r_sp,     w_sp_nxt;

  logic              w_load;
  logic [7:0]        w_cmd_byte;
  logic [15:0]       w_pixel_word;

`ifdef OLED_TEST_PATTERN_EN
  localparam logic [6:0] X_LAST = 7'(X_SIZE - 1);

  // r_col is the x coordinate of r_index, kept alongside it to avoid a modulo
  logic [6:0] r_col;
  logic [2:0] w_bar;
  logic       w_unused_pixel_data;

  assign w_unused_pixel_data = ^pixel_data;
  assign w_bar               = 3'(r_col / 7'd12);

  always_comb begin
    w_pixel_word = 16'hFFFF;
    case (w_bar)
      3'd0:    w_pixel_word = 16'hF800;
      3'd1:    w_pixel_word = 16'hFBE0;
      3'd2:    w_pixel_word = 16'hFFE0;
      3'd3:    w_pixel_word = 16'h07E0;
      3'd4:    w_pixel_word = 16'h07FF;
      3'd5:    w_pixel_word = 16'h001F;
      3'd6:    w_pixel_word = 16'hF81F;
      default: w_pixel_word = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clksig or posedge reset) begin
    if (reset) begin
      r_col <= '0;
    end else if (w_load) begin
      r_col <= (r_col == X_LAST) ? 7'd0 : r_col + 7'd1;
    end
  end
`else
  assign w_pixel_word = pixel_data;
`endif

  always_comb begin
    w_cmd_byte = 8'h00;
    case (w_byte_nxt)
      3'd0:    w_cmd_byte = 8'h15;
      3'd1:    w_cmd_byte = 8'h00;
      3'd2:    w_cmd_byte = 8'(X_SIZE - 1);
      3'd3:    w_cmd_byte = 8'h75;
      3'd4:    w_cmd_byte = 8'h00;
      3'd5:    w_cmd_byte = 8'(Y_SIZE - 1);
      default: w_cmd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clksig or posedge reset) begin
    if (reset) begin
      r_state <= S_POWERUP;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_pix   <= '0;
      r_wait  <= '0;
      r_shift <= '0;
      r_index <= '0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b0;
      r_sclk  <= 1'b1;
      r_mosi  <= 1'b0;
      r_fb    <= 1'b0;
      r_sp    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_pix   <= w_pix_nxt;
      r_wait  <= w_wait_nxt;
      r_shift <= w_shift_nxt;
      r_index <= w_index_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_dc    <= w_dc_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_fb    <= w_fb_nxt;
      r_sp    <= w_sp_nxt;
    end
  end

  // Sequencing: phase toggles every cycle while shifting; bit advances after phase 1.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = 1'b0;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_pix_nxt   = r_pix;
    w_wait_nxt  = r_wait;
    case (r_state)
      S_POWERUP: begin
        if (r_wait == PWR_LAST) begin
          w_state_nxt = S_CMD;
          w_wait_nxt  = '0;
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_CMD: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          if (r_bit == 4'd7) begin
            w_bit_nxt = '0;
            if (r_byte == 3'd5) begin
              w_byte_nxt  = '0;
              w_pix_nxt   = '0;
              w_state_nxt = S_STREAM;
            end else begin
              w_byte_nxt = r_byte + 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      S_STREAM: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          if (r_bit == 4'd15) begin
            w_bit_nxt = '0;
            if (r_pix == LAST_PIX) begin
              w_pix_nxt   = '0;
              w_wait_nxt  = '0;
              w_state_nxt = S_GAP;
            end else begin
              w_pix_nxt = r_pix + 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      default: begin
        if (r_wait == GAP_LAST) begin
          w_state_nxt = S_CMD;
          w_wait_nxt  = '0;
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
    endcase
  end

  // Outputs are computed from the next-cycle counters so every pin comes straight from a flop.
  assign w_load = (w_state_nxt == S_STREAM) && !w_phase_nxt && (w_bit_nxt == 4'd0);

  always_comb begin
    w_cs_n_nxt  = 1'b1;
    w_dc_nxt    = r_dc;
    w_sclk_nxt  = 1'b1;
    w_mosi_nxt  = r_mosi;
    w_fb_nxt    = 1'b0;
    w_sp_nxt    = 1'b0;
    w_shift_nxt = r_shift;
    w_index_nxt = r_index;
    case (w_state_nxt)
      S_POWERUP: begin
        w_dc_nxt   = 1'b0;
        w_mosi_nxt = 1'b0;
      end
      S_CMD: begin
        w_cs_n_nxt = 1'b0;
        w_dc_nxt   = 1'b0;
        w_sclk_nxt = w_phase_nxt;
        w_fb_nxt   = (r_state != S_CMD);
        if (!w_phase_nxt) w_mosi_nxt = w_cmd_byte[~w_bit_nxt[2:0]];
      end
      S_STREAM: begin
        w_cs_n_nxt = 1'b0;
        w_dc_nxt   = 1'b1;
        w_sclk_nxt = w_phase_nxt;
        w_sp_nxt   = 1'b1;
        if (w_load) begin
          // pixel_data belongs to r_index now; the painter gets the next index for a whole pixel time
          w_shift_nxt = w_pixel_word;
          w_mosi_nxt  = w_pixel_word[15];
          w_index_nxt = (r_index == LAST_PIX) ? 13'd0 : r_index + 13'd1;
        end else if (!w_phase_nxt) begin
          w_mosi_nxt = r_shift[~w_bit_nxt];
        end
      end
      default: begin
        w_dc_nxt = 1'b1;
      end
    endcase
  end

  assign pixel_index    = r_index;
  assign cs_n           = r_cs_n;
  assign dc             = r_dc;
  assign sclk           = r_sclk;
  assign mosi           = r_mosi;
  assign frame_begin    = r_fb;
  assign sending_pixels = r_sp;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Bench for oled_pixel_streamer on a 96x4 raster: SPI decoder pops a scoreboard of expected command bytes and pixel words.
module tb_oled_pixel_streamer;

  localparam int TB_X  = 96;
  localparam int TB_Y  = 4;
  localparam int TB_P  = 4;
  localparam int TB_G  = 2;
  localparam int NPIX  = TB_X * TB_Y;
  localparam int FRAME = 96 + NPIX * 32 + TB_G;

  logic        clksig = 1'b0;
  logic        reset  = 1'b0;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic        cs_n, dc, sclk, mosi, frame_begin, sending_pixels;

  logic        painter_const = 1'b1;
  logic [16:0] sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fb_n     = 0;
  int fb_t[8];
  int stream_done = 0;
  int viol     = 0;
  int max_idx  = 0;

  oled_pixel_streamer #(
    .X_SIZE(TB_X), .Y_SIZE(TB_Y), .POWERUP_CYCLES(TB_P), .GAP_CYCLES(TB_G)
  ) dut (
    .clksig(clksig), .reset(reset), .pixel_data(pixel_data), .pixel_index(pixel_index),
    .cs_n(cs_n), .dc(dc), .sclk(sclk), .mosi(mosi),
    .frame_begin(frame_begin), .sending_pixels(sending_pixels)
  );

  always #5 clksig = ~clksig;
  always @(posedge clksig) cyc <= cyc + 1;

  // Painter model: combinational from pixel_index
  always_comb pixel_data = painter_const ? 16'hF800 : {3'b000, pixel_index};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_word(input int n, input logic cnst);
`ifdef OLED_TEST_PATTERN_EN
    case ((n % TB_X) / 12)
      0: return 16'hF800;
      1: return 16'hFBE0;
      2: return 16'hFFE0;
      3: return 16'h07E0;
      4: return 16'h07FF;
      5: return 16'h001F;
      6: return 16'hF81F;
      default: return 16'hFFFF;
    endcase
`else
    return cnst ? 16'hF800 : 16'(n);
`endif
  endfunction

  task automatic push_frame(input logic cnst);
    logic [7:0] cmd[6];
    cmd = '{8'h15, 8'h00, 8'(TB_X - 1), 8'h75, 8'h00, 8'(TB_Y - 1)};
    for (int i = 0; i < 6; i++) sb.push_back({1'b0, 8'h00, cmd[i]});
    for (int n = 0; n < NPIX; n++) sb.push_back({1'b1, exp_word(n, cnst)});
  endtask

  // SPI decoder / protocol monitor, sampled on the falling edge
  logic [15:0] acc;
  int          nbits;
  logic        wdc, p_mosi, p_dc, prev_sp, armed;
  int          gap_n;
  logic [16:0] e;

  always @(negedge clksig) begin
    if (reset) begin
      acc = '0; nbits = 0; prev_sp = 1'b0; armed = 1'b0; gap_n = 0;
    end else begin
      if (frame_begin) begin
        if (fb_n < 8) fb_t[fb_n] = cyc;
        fb_n++;
        chk("fb_cs_n", {31'b0, cs_n}, 0);
        chk("fb_dc", {31'b0, dc}, 0);
      end
      if (!cs_n && sclk) begin
        if (mosi !== p_mosi || dc !== p_dc) viol++;
        if (nbits == 0) wdc = dc;
        else if (dc !== wdc) viol++;
        acc = {acc[14:0], mosi};
        nbits++;
        if ((!wdc && nbits == 8) || (wdc && nbits == 16)) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk(wdc ? "pix_word" : "cmd_byte", {15'b0, wdc, acc}, {15'b0, e});
          end
          acc = '0; nbits = 0;
        end
      end
      if (sending_pixels && !prev_sp) chk("first_pix_index", {19'b0, pixel_index}, 1);
      if (!sending_pixels && prev_sp) begin
        stream_done++;
        chk("index_wrap", {19'b0, pixel_index}, 0);
        armed = 1'b1; gap_n = 0;
      end
      if (sending_pixels && int'(pixel_index) > max_idx) max_idx = int'(pixel_index);
      if (armed) begin
        if (cs_n) gap_n++;
        else begin
          chk("gap_cs_high", gap_n, TB_G);
          armed = 1'b0;
        end
      end
      prev_sp = sending_pixels;
    end
    p_mosi = mosi;
    p_dc   = dc;
  end

  task automatic count_powerup();
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clksig);
      if (cs_n) n++;
      else break;
    end
    chk("powerup_cs_high", n, TB_P);
  endtask

  task automatic wait_fb(input int target, input int budget);
    for (int i = 0; i < budget && fb_n < target; i++) @(posedge clksig);
    chk("fb_reached", {31'b0, fb_n >= target}, 1);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_cs_n", {31'b0, cs_n}, 1);
    chk("rst_dc", {31'b0, dc}, 0);
    chk("rst_sclk", {31'b0, sclk}, 1);
    chk("rst_mosi", {31'b0, mosi}, 0);
    chk("rst_index", {19'b0, pixel_index}, 0);
    chk("rst_fb", {31'b0, frame_begin}, 0);
    chk("rst_sp", {31'b0, sending_pixels}, 0);

    push_frame(1'b1);
    push_frame(1'b0);
    push_frame(1'b0);
    repeat (3) @(posedge clksig);
    #1 reset = 1'b0;
    count_powerup();

    wait_fb(2, FRAME + 200);
    painter_const = 1'b0;
    wait_fb(3, FRAME + 200);
    chk("fb_period_1", fb_t[1] - fb_t[0], FRAME);
    chk("fb_period_2", fb_t[2] - fb_t[1], FRAME);

    // Reset lands mid-pixel in the third frame
    repeat (1000) @(posedge clksig);
    #2;
    chk("mid_sending", {31'b0, sending_pixels}, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs_n", {31'b0, cs_n}, 1);
    chk("mid_rst_sclk", {31'b0, sclk}, 1);
    chk("mid_rst_index", {19'b0, pixel_index}, 0);
    chk("mid_rst_sp", {31'b0, sending_pixels}, 0);
    sb.delete();
    push_frame(1'b0);
    repeat (3) @(posedge clksig);
    #1 reset = 1'b0;
    count_powerup();
    wait_fb(4, 200);

    for (int i = 0; i < FRAME + 200 && stream_done < 3; i++) @(posedge clksig);
    chk("last_frame_done", stream_done, 3);
    repeat (10) @(posedge clksig);
    chk("sb_drained", sb.size(), 0);
    chk("phase1_stable", viol, 0);
    chk("index_max", max_idx, NPIX - 1);
    chk("fb_count", fb_n, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_pixel_streamer.md
Name: oled_pixel_streamer

Overview:
- Display-side master for the pixel_index/pixel_data interface used by all screen-drawing blocks (for example, pixel painters that map index to colour).
- Drives pixel_index across a 96x64 raster and samples the painter's RGB565 pixel_data.
- Serialises each frame as a 4-wire SPI stream (cs_n, dc, sclk, mosi) to the SSD1331-class OLED.
- Re-sends the column/row window command before every frame, so the panel address pointer cannot drift.

Parameters:
- X_SIZE, 96: pixels per row.
- Y_SIZE, 64: rows per frame. Frame length is X_SIZE*Y_SIZE = 6144.
- POWERUP_CYCLES, 20: clksig cycles to hold cs_n high after reset before the first command byte.
- GAP_CYCLES, 2: cs_n-high cycles between frames (minimum 1).

Ports:
- clksig  in  1  system clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- pixel_data  in  16  RGB565 colour for the current pixel_index; may be combinational from pixel_index.
- pixel_index  out  13  raster address, row-major: x = index % X_SIZE, y = index / X_SIZE.
- cs_n  out  1  SPI chip select, active low.
- dc  out  1  0 = command byte, 1 = pixel data.
- sclk  out  1  SPI clock; idles high.
- mosi  out  1  SPI data, MSB first.
- frame_begin  out  1  one-cycle pulse on entry to CMD.
- sending_pixels  out  1  high throughout STREAM.

Behaviour:
- Reset (asynchronous, active-high) forces the following immediately, including mid-byte:
  - FSM to POWERUP.
  - cs_n=1, dc=0, sclk=1, mosi=0.
  - pixel_index=0, frame_begin=0, sending_pixels=0.
  - All counters cleared.
- Bit timing, 2 clksig cycles per bit:
  - Phase 0: sclk=0, mosi updated to the next bit.
  - Phase 1: sclk=1, panel samples on the rising edge.
  - One byte = 16 cycles; one pixel = 32 cycles.
- FSM states:
  - POWERUP: count POWERUP_CYCLES with cs_n=1, then go to CMD.
  - CMD: pulse frame_begin and drive cs_n=0, dc=0. Shift 6 bytes back to back: 0x15, 0x00, X_SIZE-1, 0x75, 0x00, Y_SIZE-1 (0x5F and 0x3F at defaults). Takes 96 cycles, then go to STREAM. pixel_index is held at 0 throughout CMD.
  - STREAM: drive cs_n=0, dc=1, sending_pixels=1.
    - On the first cycle of pixel n, load the 16-bit shifter from pixel_data; the sampled pixel_index equals n.
    - In that same cycle, pixel_index advances to n+1, so the painter gets 32 cycles to settle.
    - pixel_data is sampled only on load cycles.
    - After the load of pixel 6143, pixel_index wraps to 0. When the last bit of 6143 completes, go to GAP.
  - GAP: cs_n=1, sclk=1, dc=1 held, for GAP_CYCLES cycles, then go to CMD.
- Frame period = 96 + 6144*32 + GAP_CYCLES = 196706 cycles at defaults.
- Counter widths:
  - Bit counter: 4 bits.
  - Byte counter: 3 bits.
  - Pixel counter: 13 bits.
  - Power-up/gap counter: $clog2 of the larger of POWERUP_CYCLES and GAP_CYCLES, plus 1.
- Wrap boundaries:
  - pixel_index never exceeds 6143.
  - There are no extra idle cycles between bytes or pixels inside a frame. cs_n stays low from the first CMD bit to the last STREAM bit.
- Signal timing: mosi and dc change only in phase 0 or while cs_n=1. All outputs are registered.

Optional Feature:
- Macro: OLED_TEST_PATTERN_EN.
- When defined, the shifter loads an internal 8-bar colour pattern instead of pixel_data.
  - The bar is selected by x/12.
  - Bar colours in order: F800, FBE0, FFE0, 07E0, 07FF, 001F, F81F, FFFF.
  - The pixel_data port remains but is ignored; pixel_index still sequences normally.
- When undefined, pixel_data is always used, and no pattern logic is synthesised.

Test Plan:
- Reset release, POWERUP_CYCLES=4 -> cs_n=1 for 4 cycles. Then cs_n falls, frame_begin pulses once, and the mosi bytes decode to 15,00,5F,75,00,3F with dc=0 on every sclk rise.
- Constant pixel_data=16'hF800 -> the first STREAM pixel bits on sclk rises are 1111100000000000 with dc=1, and pixel_index=1 during that pixel.
- pixel_data driven as a function {3'b0,pixel_index} -> each decoded pixel word equals its position 0..6143. pixel_index wraps to 0 after load 6143.
- Count frame_begin spacing over 2 frames -> exactly 196706 cycles, with cs_n high for exactly 2 cycles between frames.
- Assert reset at cycle 1000 mid-pixel -> same cycle: cs_n=1, sclk=1, pixel_index=0. After release, the full POWERUP + CMD sequence repeats.
- OLED_TEST_PATTERN_EN defined, pixel_data=0 -> pixel x=0 decodes F800, x=50 decodes 07FF, x=95 decodes FFFF.
